// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory, decode-handshake and redirect signals around the fetch unit
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  modport master (
    output imem_addr, out_valid, out_instr, out_pc,
    input  imem_instr, out_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc,
    output imem_instr, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer that waits out imem latency, captures the word and hands {instr, pc} to decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  fetch_unit_if.master bus
);
  localparam logic [0:0] WAIT = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  logic [0:0]  state;
  logic [3:0]  wait_cnt;
  logic [31:0] addr, instr, pc;
  logic        valid;
  assign bus.imem_addr = addr;
  assign bus.out_valid = valid;
  assign bus.out_instr = instr;
  assign bus.out_pc    = pc;
  // redirect outranks both the capture and an accept on the same edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr     <= {RESET_PC[31:2], 2'b00};
      valid    <= 1'b0;
      instr    <= '0;
      pc       <= '0;
      wait_cnt <= '0;
      state    <= WAIT;
    end else if (bus.redirect_valid) begin
      addr     <= {bus.redirect_pc[31:2], 2'b00};
      valid    <= 1'b0;
      wait_cnt <= '0;
      state    <= WAIT;
    end else if (state == WAIT) begin
      if (wait_cnt == 4'(WAIT_CYCLES - 1)) begin
        instr    <= bus.imem_instr;
        pc       <= addr;
        valid    <= 1'b1;
        wait_cnt <= '0;
        state    <= HOLD;
      end else
        wait_cnt <= wait_cnt + 4'd1;
    end else if (bus.out_ready) begin
      addr  <= addr + 32'd4;
      valid <= 1'b0;
      state <= WAIT;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch latency, back-pressure, redirects, wrap and async reset
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] d1 = '0;
  logic [31:0] h_instr, h_pc;
  fetch_unit_if bus ();
  fetch_unit #(.RESET_PC(32'h0), .WAIT_CYCLES(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2002_0005 : {16'hC0DE, a[17:2]};
  endfunction
  // one-cycle registered read so the data settles within the 2-cycle wait window
  always_ff @(posedge clk) d1 <= mem(bus.imem_addr);
  assign bus.imem_instr = d1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    tick;
    tick;
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_instr", bus.out_instr, 32'h0);
    chk("rst_pc", bus.out_pc, 32'h0);
    reset = 1'b0;
    tick;
    chk("first_wait", {31'b0, bus.out_valid}, 32'h0);
    tick;
    chk("first_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("first_instr", bus.out_instr, 32'h2002_0005);
    chk("first_pc", bus.out_pc, 32'h0);
    tick;
    chk("accept_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("accept_addr", bus.imem_addr, 32'h4);
    tick;
    tick;
    chk("pc4_pc", bus.out_pc, 32'h4);
    chk("pc4_instr", bus.out_instr, 32'hC0DE_0001);
    tick;
    chk("pc8_addr", bus.imem_addr, 32'h8);
    tick;
    bus.out_ready = 1'b0;
    tick;
    chk("bp_valid0", {31'b0, bus.out_valid}, 32'h1);
    h_instr = bus.out_instr;
    h_pc = bus.out_pc;
    chk("bp_pc0", h_pc, 32'h8);
    chk("bp_instr0", h_instr, 32'hC0DE_0002);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_valid", {31'b0, bus.out_valid}, 32'h1);
      chk("bp_instr", bus.out_instr, 32'hC0DE_0002);
      chk("bp_pc", bus.out_pc, 32'h8);
      chk("bp_addr", bus.imem_addr, 32'h8);
    end
    bus.out_ready = 1'b1;
    tick;
    chk("bp_release_addr", bus.imem_addr, 32'hC);
    chk("bp_release_valid", {31'b0, bus.out_valid}, 32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h4;
    tick;
    chk("redir4_addr", bus.imem_addr, 32'h4);
    bus.redirect_valid = 1'b0;
    tick;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h43;
    tick;
    chk("redir_wait_addr", bus.imem_addr, 32'h40);
    chk("redir_wait_valid", {31'b0, bus.out_valid}, 32'h0);
    bus.redirect_valid = 1'b0;
    tick;
    chk("redir_wait_restart", {31'b0, bus.out_valid}, 32'h0);
    tick;
    chk("redir_wait_valid2", {31'b0, bus.out_valid}, 32'h1);
    chk("redir_wait_pc", bus.out_pc, 32'h40);
    chk("redir_wait_instr", bus.out_instr, 32'hC0DE_0010);
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h10;
    tick;
    chk("redir16_addr", bus.imem_addr, 32'h10);
    bus.redirect_valid = 1'b0;
    tick;
    tick;
    chk("hold16_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("hold16_pc", bus.out_pc, 32'h10);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    bus.out_ready = 1'b1;
    tick;
    chk("race_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("race_addr", bus.imem_addr, 32'h100);
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b0;
    tick;
    tick;
    chk("race_next_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("race_next_pc", bus.out_pc, 32'h100);
    chk("race_next_instr", bus.out_instr, 32'hC0DE_0040);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick;
    bus.redirect_valid = 1'b0;
    tick;
    tick;
    chk("top_pc", bus.out_pc, 32'hFFFF_FFFC);
    chk("top_instr", bus.out_instr, 32'hC0DE_FFFF);
    bus.out_ready = 1'b1;
    tick;
    chk("wrap_addr", bus.imem_addr, 32'h0);
    bus.out_ready = 1'b0;
    tick;
    tick;
    chk("wrap_pc", bus.out_pc, 32'h0);
    chk("wrap_instr", bus.out_instr, 32'h2002_0005);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    tick;
    bus.redirect_valid = 1'b0;
    tick;
    chk("pre_rst_addr", bus.imem_addr, 32'h200);
    #2 reset = 1'b1;
    #1;
    chk("async_addr", bus.imem_addr, 32'h0);
    chk("async_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("async_instr", bus.out_instr, 32'h0);
    #2 reset = 1'b0;
    tick;
    chk("post_rst_wait", {31'b0, bus.out_valid}, 32'h0);
    tick;
    chk("post_rst_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("post_rst_pc", bus.out_pc, 32'h0);
    chk("post_rst_instr", bus.out_instr, 32'h2002_0005);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
